// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / host side and the receive FIFO.
// The master drives writes, pops and control; the slave returns data and status.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  in_parity_err;
    logic                  in_rx_error;
    logic                  in_overrun;
    logic                  flush;
    logic                  rd_en;
    logic                  overrun_clr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_parity_err;
    logic                  rd_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic [LW-1:0]         level;
    logic                  overrun_flag;
    logic [7:0]            drop_count;

    modport master (
        output wr_data, wr_valid, in_parity_err, in_rx_error,
        output in_overrun, flush, rd_en, overrun_clr,
        input  rd_data, rd_parity_err, rd_valid, fifo_full,
        input  fifo_empty, almost_full, level, overrun_flag, drop_count
    );

    modport slave (
        input  wr_data, wr_valid, in_parity_err, in_rx_error,
        input  in_overrun, flush, rd_en, overrun_clr,
        output rd_data, rd_parity_err, rd_valid, fifo_full,
        output fifo_empty, almost_full, level, overrun_flag, drop_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: parity-tagged words, registered pop, status flags,
// sticky overrun and a saturating count of frames the receiver abandoned.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input logic            clk,
    input logic            rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef logic [DATA_WIDTH:0] entry_t;

    entry_t                mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_par_q, rd_par_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;
    logic                  pop_ok;
    logic                  wr_ok;
    logic                  ovf_set;
    entry_t                head;

    always_comb begin
        pop_ok     = bus.rd_en && !empty_q && !bus.flush;
        wr_ok      = bus.wr_valid && (!full_q || pop_ok) && !bus.flush;
        head       = mem_q[rptr_q];
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_par_d   = rd_par_q;
        rd_valid_d = pop_ok;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_ok)  wptr_d = wptr_q + AW'(1);
            if (pop_ok) rptr_d = rptr_q + AW'(1);
            unique case ({wr_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        if (pop_ok) begin
            rd_data_d = head[DATA_WIDTH-1:0];
            rd_par_d  = head[DATA_WIDTH];
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
        afull_d = (level_d >= LW'(AFULL_LEVEL));

        // Parity pulse belongs to the frame still in progress, so a write
        // in the same cycle consumes the old flag and the pulse re-arms it.
        pend_d = pend_q;
        if (wr_ok)             pend_d = 1'b0;
        if (bus.in_parity_err) pend_d = 1'b1;
        if (bus.in_rx_error)   pend_d = 1'b0;
        if (bus.flush)         pend_d = 1'b0;

        ovf_set = bus.in_overrun ||
                  (bus.wr_valid && full_q && !pop_ok && !bus.flush);
        ovf_d = ovf_q;
        if (bus.overrun_clr) ovf_d = 1'b0;
        if (ovf_set)         ovf_d = 1'b1;

        drop_d = drop_q;
        if (bus.in_rx_error && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= {pend_q, bus.wr_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_par_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            pend_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            rd_data_q  <= rd_data_d;
            rd_par_q   <= rd_par_d;
            rd_valid_q <= rd_valid_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_parity_err = rd_par_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.fifo_full     = full_q;
    assign bus.fifo_empty    = empty_q;
    assign bus.almost_full   = afull_q;
    assign bus.level         = level_q;
    assign bus.overrun_flag  = ovf_q;
    assign bus.drop_count    = drop_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: per-feature tasks with inline checks.
// Inputs change 1 ns after the rising edge; outputs are read there too.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) b ();

    uart_rx_fifo #(
        .DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        b.wr_valid = 1'b1;
        b.wr_data  = d;
        tick();
        b.wr_valid = 1'b0;
    endtask

    task automatic pop();
        b.rd_en = 1'b1;
        tick();
        b.rd_en = 1'b0;
    endtask

    task automatic pulse_rx_err();
        b.in_rx_error = 1'b1;
        tick();
        b.in_rx_error = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (b.fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", b.fifo_empty); end
        n_cmp++; if (b.level !== 5'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", b.level); end
        n_cmp++; if ({b.fifo_full, b.almost_full, b.rd_valid, b.rd_parity_err, b.overrun_flag} !== 5'b0) begin
            n_err++; $display("FAIL rst_flags got %b exp 00000",
                {b.fifo_full, b.almost_full, b.rd_valid, b.rd_parity_err, b.overrun_flag});
        end
        n_cmp++; if (b.rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data got %h exp 00", b.rd_data); end
        n_cmp++; if (b.drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop got %0d exp 0", b.drop_count); end
    endtask

    task automatic test_basic();
        wr(8'hA5);
        wr(8'h3C);
        n_cmp++; if (b.level !== 5'd2) begin n_err++; $display("FAIL basic_lvl2 got %0d exp 2", b.level); end
        pop();
        n_cmp++; if (b.rd_valid !== 1'b1 || b.rd_data !== 8'hA5) begin
            n_err++; $display("FAIL basic_pop1 got v=%b d=%h exp v=1 d=a5", b.rd_valid, b.rd_data);
        end
        n_cmp++; if (b.level !== 5'd1) begin n_err++; $display("FAIL basic_lvl1 got %0d exp 1", b.level); end
        tick();
        n_cmp++; if (b.rd_valid !== 1'b0 || b.rd_data !== 8'hA5) begin
            n_err++; $display("FAIL basic_hold got v=%b d=%h exp v=0 d=a5", b.rd_valid, b.rd_data);
        end
        pop();
        n_cmp++; if (b.rd_valid !== 1'b1 || b.rd_data !== 8'h3C) begin
            n_err++; $display("FAIL basic_pop2 got v=%b d=%h exp v=1 d=3c", b.rd_valid, b.rd_data);
        end
        n_cmp++; if (b.level !== 5'd0 || b.fifo_empty !== 1'b1) begin
            n_err++; $display("FAIL basic_end got lvl=%0d e=%b exp lvl=0 e=1", b.level, b.fifo_empty);
        end
    endtask

    task automatic test_parity();
        b.in_parity_err = 1'b1;
        tick();
        b.in_parity_err = 1'b0;
        wr(8'h55);
        wr(8'h66);
        pop();
        n_cmp++; if (b.rd_data !== 8'h55 || b.rd_parity_err !== 1'b1) begin
            n_err++; $display("FAIL par_first got d=%h p=%b exp d=55 p=1", b.rd_data, b.rd_parity_err);
        end
        pop();
        n_cmp++; if (b.rd_data !== 8'h66 || b.rd_parity_err !== 1'b0) begin
            n_err++; $display("FAIL par_second got d=%h p=%b exp d=66 p=0", b.rd_data, b.rd_parity_err);
        end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) begin
            wr(8'h10 + 8'(i));
            if (i == 10) begin
                n_cmp++; if (b.almost_full !== 1'b0 || b.level !== 5'd11) begin
                    n_err++; $display("FAIL afull_11 got af=%b lvl=%0d exp af=0 lvl=11", b.almost_full, b.level);
                end
            end
            if (i == 11) begin
                n_cmp++; if (b.almost_full !== 1'b1 || b.fifo_full !== 1'b0) begin
                    n_err++; $display("FAIL afull_12 got af=%b f=%b exp af=1 f=0", b.almost_full, b.fifo_full);
                end
            end
        end
        n_cmp++; if (b.fifo_full !== 1'b1 || b.level !== 5'd16 || b.overrun_flag !== 1'b0) begin
            n_err++; $display("FAIL full16 got f=%b lvl=%0d ov=%b exp f=1 lvl=16 ov=0",
                b.fifo_full, b.level, b.overrun_flag);
        end
        wr(8'hEE);
        n_cmp++; if (b.overrun_flag !== 1'b1 || b.level !== 5'd16) begin
            n_err++; $display("FAIL drop17 got ov=%b lvl=%0d exp ov=1 lvl=16", b.overrun_flag, b.level);
        end
        b.overrun_clr = 1'b1;
        tick();
        b.overrun_clr = 1'b0;
        n_cmp++; if (b.overrun_flag !== 1'b0) begin n_err++; $display("FAIL ov_clr got %b exp 0", b.overrun_flag); end
    endtask

    task automatic test_full_wr_pop();
        b.wr_valid = 1'b1;
        b.wr_data  = 8'h99;
        b.rd_en    = 1'b1;
        tick();
        b.wr_valid = 1'b0;
        b.rd_en    = 1'b0;
        n_cmp++; if (b.rd_valid !== 1'b1 || b.rd_data !== 8'h10) begin
            n_err++; $display("FAIL fwp_pop got v=%b d=%h exp v=1 d=10", b.rd_valid, b.rd_data);
        end
        n_cmp++; if (b.level !== 5'd16 || b.fifo_full !== 1'b1 || b.overrun_flag !== 1'b0) begin
            n_err++; $display("FAIL fwp_lvl got lvl=%0d f=%b ov=%b exp lvl=16 f=1 ov=0",
                b.level, b.fifo_full, b.overrun_flag);
        end
        for (int i = 1; i < 16; i++) begin
            pop();
            n_cmp++; if (b.rd_data !== 8'h10 + 8'(i)) begin
                n_err++; $display("FAIL drain_%0d got %h exp %h", i, b.rd_data, 8'h10 + 8'(i));
            end
        end
        pop();
        n_cmp++; if (b.rd_data !== 8'h99 || b.fifo_empty !== 1'b1) begin
            n_err++; $display("FAIL drain_last got d=%h e=%b exp d=99 e=1", b.rd_data, b.fifo_empty);
        end
    endtask

    task automatic test_overrun_pin();
        b.in_overrun  = 1'b1;
        b.overrun_clr = 1'b1;
        tick();
        b.in_overrun  = 1'b0;
        n_cmp++; if (b.overrun_flag !== 1'b1) begin n_err++; $display("FAIL ov_set_wins got %b exp 1", b.overrun_flag); end
        tick();
        b.overrun_clr = 1'b0;
        n_cmp++; if (b.overrun_flag !== 1'b0) begin n_err++; $display("FAIL ov_clr2 got %b exp 0", b.overrun_flag); end
    endtask

    task automatic test_rx_error();
        b.in_parity_err = 1'b1;
        tick();
        b.in_parity_err = 1'b0;
        pulse_rx_err();
        wr(8'h12);
        pop();
        n_cmp++; if (b.rd_data !== 8'h12 || b.rd_parity_err !== 1'b0 || b.drop_count !== 8'd1) begin
            n_err++; $display("FAIL rxerr got d=%h p=%b dc=%0d exp d=12 p=0 dc=1",
                b.rd_data, b.rd_parity_err, b.drop_count);
        end
        for (int i = 0; i < 253; i++) begin
            pulse_rx_err();
            tick();
        end
        n_cmp++; if (b.drop_count !== 8'd254) begin n_err++; $display("FAIL drop_254 got %0d exp 254", b.drop_count); end
        for (int i = 0; i < 46; i++) begin
            pulse_rx_err();
            tick();
        end
        n_cmp++; if (b.drop_count !== 8'd255) begin n_err++; $display("FAIL drop_sat got %0d exp 255", b.drop_count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) wr(8'h21 + 8'(i));
        n_cmp++; if (b.level !== 5'd5) begin n_err++; $display("FAIL fl_lvl5 got %0d exp 5", b.level); end
        b.flush    = 1'b1;
        b.wr_valid = 1'b1;
        b.wr_data  = 8'h77;
        tick();
        b.flush    = 1'b0;
        b.wr_valid = 1'b0;
        n_cmp++; if (b.level !== 5'd0 || b.fifo_empty !== 1'b1) begin
            n_err++; $display("FAIL fl_clear got lvl=%0d e=%b exp lvl=0 e=1", b.level, b.fifo_empty);
        end
        n_cmp++; if (b.rd_data !== 8'h12 || b.drop_count !== 8'd255) begin
            n_err++; $display("FAIL fl_keep got d=%h dc=%0d exp d=12 dc=255", b.rd_data, b.drop_count);
        end
        pop();
        n_cmp++; if (b.rd_valid !== 1'b0 || b.level !== 5'd0) begin
            n_err++; $display("FAIL empty_pop got v=%b lvl=%0d exp v=0 lvl=0", b.rd_valid, b.level);
        end
        wr(8'h31);
        pop();
        n_cmp++; if (b.rd_data !== 8'h31) begin n_err++; $display("FAIL fl_nowrite got %h exp 31", b.rd_data); end
    endtask

    task automatic test_reset_mid();
        wr(8'h41);
        wr(8'h42);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (b.level !== 5'd0 || b.fifo_empty !== 1'b1 || b.drop_count !== 8'd0 || b.rd_data !== 8'h00) begin
            n_err++; $display("FAIL async_rst got lvl=%0d e=%b dc=%0d d=%h exp 0 1 0 00",
                b.level, b.fifo_empty, b.drop_count, b.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        b.wr_data       = '0;
        b.wr_valid      = 1'b0;
        b.in_parity_err = 1'b0;
        b.in_rx_error   = 1'b0;
        b.in_overrun    = 1'b0;
        b.flush         = 1'b0;
        b.rd_en         = 1'b0;
        b.overrun_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_basic();
        test_parity();
        test_fill_overrun();
        test_full_wr_pop();
        test_overrun_pin();
        test_rx_error();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
